vram_rect_fill: RTL

- Command-driven framebuffer writer that drives the VRAM write port (we/addr/data) of the VGA display block; it is the producer end of the port the scan-out controller reads.
- Accepts one rectangle-fill command at a time and writes a solid 12-bit colour into every pixel of that rectangle, clipped to the screen. It writes one pixel per clock in row-major order.
- Sits between game/graphics logic and the vga top-level, in the vram_clk domain.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/rect_clip.sv | 30 +++
 rtl/vram_rect_fill.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants, fill FSM encoding and RGB444 field helpers.
package vga_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int VRAM_AW  = 19;
  localparam int COLOR_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  function automatic logic [3:0] rgb_r(input logic [COLOR_W-1:0] c);
    return c[11:8];
  endfunction

  function automatic logic [3:0] rgb_g(input logic [COLOR_W-1:0] c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] rgb_b(input logic [COLOR_W-1:0] c);
    return c[3:0];
  endfunction

  function automatic logic [COLOR_W-1:0] rgb_pack(input logic [3:0] r, input logic [3:0] g,
                                                  input logic [3:0] b);
    return {r, g, b};
  endfunction
endpackage

// File: rtl/rect_clip.sv
// Clips a rectangle to the screen: exclusive end column/row and an empty flag.
// Purely combinational; the caller registers the results.
module rect_clip
  import vga_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H
) (
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic [9:0]  i_w,
  input  logic [8:0]  i_h,
  output logic [10:0] o_xe,
  output logic [9:0]  o_ye,
  output logic        o_empty
);
  localparam logic [10:0] W_L = 11'(WIDTH);
  localparam logic [9:0]  H_L = 10'(HEIGHT);

  logic [10:0] w_xsum;
  logic [9:0]  w_ysum;

  // One extra bit on each sum so x+w and y+h cannot wrap before the clamp.
  assign w_xsum  = {1'b0, i_x} + {1'b0, i_w};
  assign w_ysum  = {1'b0, i_y} + {1'b0, i_h};
  assign o_xe    = (w_xsum > W_L) ? W_L : w_xsum;
  assign o_ye    = (w_ysum > H_L) ? H_L : w_ysum;
  assign o_empty = (i_w == 10'd0) || (i_h == 9'd0) ||
                   ({1'b0, i_x} >= W_L) || ({1'b0, i_y} >= H_L);
endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle fill into VRAM, one pixel per clock row-major; first write 2 cycles after accept.
// No write backpressure; cmd_ready only in IDLE, abort ends the fill after the current write.
module vram_rect_fill
  import vga_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H,
  parameter int AW     = VRAM_AW
) (
  input  logic               vram_clk,
  input  logic               clrn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_x,
  input  logic [8:0]         cmd_y,
  input  logic [9:0]         cmd_w,
  input  logic [8:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  output logic               we,
  output logic [AW-1:0]      addr,
  output logic [COLOR_W-1:0] data,
  output logic               busy,
  output logic               done
);
  localparam logic [AW-1:0] W_A = AW'(WIDTH);

  fill_state_t        r_state, w_state_nxt;
  logic [9:0]         r_cx, r_cw;
  logic [8:0]         r_cy, r_ch;
  logic [COLOR_W-1:0] r_color;
  logic [9:0]         r_xs, r_x;
  logic [8:0]         r_y;
  logic [10:0]        r_xe;
  logic [9:0]         r_ye;
  logic [AW-1:0]      r_row_base, r_addr;
  logic [COLOR_W-1:0] r_data;

  logic [10:0]   w_xe;
  logic [9:0]    w_ye;
  logic          w_empty;
  logic [AW-1:0] w_setup_base;
  logic          w_row_end, w_last;

  rect_clip #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_clip (
    .i_x     (r_cx),
    .i_y     (r_cy),
    .i_w     (r_cw),
    .i_h     (r_ch),
    .o_xe    (w_xe),
    .o_ye    (w_ye),
    .o_empty (w_empty)
  );

  assign w_setup_base = AW'(r_cy) * W_A;
  assign w_row_end    = (({1'b0, r_x} + 11'd1) == r_xe);
  assign w_last       = w_row_end && (({1'b0, r_y} + 10'd1) == r_ye);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = (abort || w_empty) ? DONE : FILL;
      FILL:    if (abort || w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vram_clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_x/r_y/r_addr always describe the write currently on the port.
  always_ff @(posedge vram_clk or negedge clrn) begin
    if (!clrn) begin
      r_cx       <= '0;
      r_cy       <= '0;
      r_cw       <= '0;
      r_ch       <= '0;
      r_color    <= '0;
      r_xs       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_xe       <= '0;
      r_ye       <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      if (r_state == IDLE && cmd_valid) begin
        r_cx    <= cmd_x;
        r_cy    <= cmd_y;
        r_cw    <= cmd_w;
        r_ch    <= cmd_h;
        r_color <= cmd_color;
      end
      if (r_state == SETUP && w_state_nxt == FILL) begin
        r_xs       <= r_cx;
        r_x        <= r_cx;
        r_y        <= r_cy;
        r_xe       <= w_xe;
        r_ye       <= w_ye;
        r_row_base <= w_setup_base;
        r_addr     <= w_setup_base + AW'(r_cx);
        r_data     <= r_color;
      end
      if (r_state == FILL && w_state_nxt == FILL) begin
        if (w_row_end) begin
          r_x        <= r_xs;
          r_y        <= r_y + 9'd1;
          r_row_base <= r_row_base + W_A;
          r_addr     <= r_row_base + W_A + AW'(r_xs);
        end else begin
          r_x    <= r_x + 10'd1;
          r_addr <= r_addr + AW'(1);
        end
      end
    end
  end

  assign we        = (r_state == FILL);
  assign done      = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign cmd_ready = (r_state == IDLE);
  assign addr      = r_addr;
  assign data      = r_data;
endmodule
